cla_pipe_adder16: RTL and testbench

CLA_PIPE_ADDER16 -- requirements
Module: cla_pipe_adder16

---
 rtl/cla_pipe_adder16.sv | 157 +++++++++++++++
 tb/tb_cla_pipe_adder16.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder16.sv
// cla_pipe_adder16: WIDTH-bit adder pipelined as WIDTH/4 stages of 4-bit
// carry-lookahead slices, with a valid/ready handshake on both sides.
// Stage k adds bits [4k+3:4k] using the carry registered by stage k-1.
// Optional feature: define CLA_PIPE_OVF_EN to add the registered signed
// overflow output Ovf, aligned with Sum.
module cla_pipe_adder16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid,
`ifdef CLA_PIPE_OVF_EN
    output logic             Ovf,
`endif
    input  logic             out_ready
);

    // WIDTH must be a multiple of 4, at least 4.
    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned MSB    = WIDTH - 1;

    // 4-bit carry-lookahead slice: every carry is a flat G/P expression of ci.
    // Returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Per-stage registers: forwarded operands, partially built sum, slice carry, valid.
    logic [WIDTH-1:0]  a_q   [NSLICE];
    logic [WIDTH-1:0]  b_q   [NSLICE];
    logic [WIDTH-1:0]  sum_q [NSLICE];
    logic [NSLICE-1:0] c_q;
    logic [NSLICE-1:0] v_q;

    // Next values for every stage register.
    logic [WIDTH-1:0]  nxt_a   [NSLICE];
    logic [WIDTH-1:0]  nxt_b   [NSLICE];
    logic [WIDTH-1:0]  nxt_sum [NSLICE];
    logic [NSLICE-1:0] nxt_c;
    logic [NSLICE-1:0] nxt_v;

    logic advance;

    // Whole pipeline moves when the output slot is empty or being drained.
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    genvar k;
    generate
        for (k = 0; k < NSLICE; k++) begin : g_stage
            logic [WIDTH-1:0] pa;
            logic [WIDTH-1:0] pb;
            logic [WIDTH-1:0] ps;
            logic             pc;
            logic             pv;
            logic [4:0]       res;
            logic [WIDTH-1:0] merged;

            if (k == 0) begin : g_first
                // Stage 0 takes the live inputs; an invalid input becomes a bubble.
                assign pa = A;
                assign pb = B;
                assign ps = '0;
                assign pc = Cin;
                assign pv = in_valid;
            end else begin : g_rest
                // Later stages take the previous stage's registers.
                assign pa = a_q[k-1];
                assign pb = b_q[k-1];
                assign ps = sum_q[k-1];
                assign pc = c_q[k-1];
                assign pv = v_q[k-1];
            end

            assign res = cla4(pa[4*k +: 4], pb[4*k +: 4], pc);

            // Insert this slice's sum bits into the forwarded partial sum.
            always_comb begin
                merged           = ps;
                merged[4*k +: 4] = res[3:0];
            end

            assign nxt_a[k]   = pa;
            assign nxt_b[k]   = pb;
            assign nxt_sum[k] = merged;
            assign nxt_c[k]   = res[4];
            assign nxt_v[k]   = pv;
        end
    endgenerate

    // Stage registers: cleared asynchronously, shift together on advance, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NSLICE); i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                sum_q[i] <= '0;
            end
            c_q <= '0;
            v_q <= '0;
        end else if (advance) begin
            for (int i = 0; i < int'(NSLICE); i++) begin
                a_q[i]   <= nxt_a[i];
                b_q[i]   <= nxt_b[i];
                sum_q[i] <= nxt_sum[i];
            end
            c_q <= nxt_c;
            v_q <= nxt_v;
        end
    end

    assign Sum       = sum_q[NSLICE-1];
    assign Cout      = c_q[NSLICE-1];
    assign out_valid = v_q[NSLICE-1];

`ifdef CLA_PIPE_OVF_EN
    logic ovf_q;
    logic nxt_ovf;

    // Carry into the MSB is recovered as sum ^ a ^ b at that bit; overflow = it ^ carry-out.
    assign nxt_ovf = nxt_sum[NSLICE-1][MSB] ^ nxt_a[NSLICE-1][MSB]
                   ^ nxt_b[NSLICE-1][MSB] ^ nxt_c[NSLICE-1];

    // Overflow flag tracks the last stage so it stays aligned with Sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= nxt_ovf;
        end
    end

    assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder16.sv
// Self-checking bench for cla_pipe_adder16 (WIDTH=16): directed vector table,
// stall, asynchronous reset and alternating-valid sequences.
module tb_cla_pipe_adder16;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum;
    logic        cout;
    logic        out_valid;
    logic        out_ready;
`ifdef CLA_PIPE_OVF_EN
    logic        ovf;
`endif

    cla_pipe_adder16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sum       (sum),
        .Cout      (cout),
        .out_valid (out_valid),
`ifdef CLA_PIPE_OVF_EN
        .Ovf       (ovf),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    localparam int NVEC = 10;
    localparam int NTOG = 12;

    vec_t        tbl [NVEC];
    int          checks;
    int          errors;
    logic [15:0] tog_sum  [NTOG];
    logic        tog_cout [NTOG];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; return 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic vv);
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = vv;
    endtask

    initial begin
        int          j;
        logic        expv;
        logic [15:0] ta;
        logic [15:0] tb;
        logic        tc;

        checks = 0;
        errors = 0;

        //             a         b         cin   sum       cout  ovf
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[4] = '{16'h00C0, 16'h00A0, 1'b1, 16'h0161, 1'b0, 1'b0};
        tbl[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[6] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        tbl[7] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
        tbl[8] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        tbl[9] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

        // Reset state
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        #3;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum",       32'(sum),       32'd0);
        chk("reset_cout",      32'(cout),      32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
`ifdef CLA_PIPE_OVF_EN
        chk("reset_ovf",       32'(ovf),       32'd0);
`endif
        #9;
        rst = 1'b0;

        // 1 + 2: result appears on the 4th edge after acceptance
        drive(16'h0001, 16'h0002, 1'b0, 1'b1);
        step();
        drive(16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            chk($sformatf("lat_valid_e%0d", e), 32'(out_valid), (e == 4) ? 32'd1 : 32'd0);
            if (e < 4) step();
        end
        chk("lat_sum",  32'(sum),  32'h0003);
        chk("lat_cout", 32'(cout), 32'd0);
        step();
        chk("lat_bubble", 32'(out_valid), 32'd0);

        // Back-to-back table stream, out_ready=1
        for (int i = 0; i < NVEC + 4; i++) begin
            if (i < NVEC) drive(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1);
            else          drive(16'h0, 16'h0, 1'b0, 1'b0);
            chk($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'd1);
            step();
            j    = i - 3;
            expv = (j >= 0) && (j < NVEC);
            chk($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'(expv));
            if (expv) begin
                chk($sformatf("stream_sum_%0d", j),  32'(sum),  32'(tbl[j].sum));
                chk($sformatf("stream_cout_%0d", j), 32'(cout), 32'(tbl[j].cout));
`ifdef CLA_PIPE_OVF_EN
                chk($sformatf("stream_ovf_%0d", j),  32'(ovf),  32'(tbl[j].ovf));
`endif
            end
        end

        // Stall: three back-to-back inputs, out_ready low for 2 cycles
        drive(16'h00C0, 16'h00A0, 1'b1, 1'b1); step();
        drive(16'h5555, 16'hAAAA, 1'b0, 1'b1); step();
        drive(16'h1234, 16'h4321, 1'b0, 1'b1); step();
        drive(16'h0000, 16'h0000, 1'b0, 1'b0); step();
        chk("stall_first_valid", 32'(out_valid), 32'd1);
        chk("stall_first_sum",   32'(sum),       32'h0161);
        out_ready = 1'b0;
        drive(16'h7777, 16'h7777, 1'b1, 1'b1);   // must be ignored
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        for (int s = 0; s < 2; s++) begin
            step();
            chk($sformatf("stall_hold_valid_%0d", s), 32'(out_valid), 32'd1);
            chk($sformatf("stall_hold_sum_%0d", s),   32'(sum),       32'h0161);
            chk($sformatf("stall_hold_cout_%0d", s),  32'(cout),      32'd0);
            chk($sformatf("stall_hold_rdy_%0d", s),   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        step();
        chk("stall_r1_valid", 32'(out_valid), 32'd1);
        chk("stall_r1_sum",   32'(sum),       32'hFFFF);
        chk("stall_r1_cout",  32'(cout),      32'd0);
        step();
        chk("stall_r2_valid", 32'(out_valid), 32'd1);
        chk("stall_r2_sum",   32'(sum),       32'h5555);
        chk("stall_r2_cout",  32'(cout),      32'd0);
        step();
        chk("stall_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle with the pipeline full
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i + 5].a, tbl[i + 5].b, tbl[i + 5].cin, 1'b1);
            step();
        end
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("arst_pre_valid", 32'(out_valid), 32'd1);
        chk("arst_pre_sum",   32'(sum),       32'(tbl[5].sum));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid",    32'(out_valid), 32'd0);
        chk("arst_sum",      32'(sum),       32'd0);
        chk("arst_cout",     32'(cout),      32'd0);
        chk("arst_in_ready", 32'(in_ready),  32'd1);
        #2;
        rst = 1'b0;
        drive(16'h0100, 16'h0200, 1'b1, 1'b1);
        step();
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            chk($sformatf("arst_after_valid_%0d", e), 32'(out_valid), (e == 4) ? 32'd1 : 32'd0);
            if (e < 4) step();
        end
        chk("arst_after_sum", 32'(sum), 32'h0301);
        step();
        chk("arst_after_bubble", 32'(out_valid), 32'd0);

        // Alternating in_valid with out_ready=1
        for (int i = 0; i < NTOG + 4; i++) begin
            if (i < NTOG && (i % 2) == 0) begin
                ta = 16'(i * 16'h1357) ^ 16'hF0F0;
                tb = 16'(i * 16'h0FED) + 16'h8421;
                tc = 1'(i / 2);
                {tog_cout[i], tog_sum[i]} = 17'(ta) + 17'(tb) + 17'(tc);
                drive(ta, tb, tc, 1'b1);
            end else begin
                drive(16'hCAFE, 16'hF00D, 1'b1, 1'b0);
            end
            step();
            j    = i - 3;
            expv = (j >= 0) && (j < NTOG) && ((j % 2) == 0);
            chk($sformatf("tog_valid_%0d", i), 32'(out_valid), 32'(expv));
            if (expv) begin
                chk($sformatf("tog_sum_%0d", j),  32'(sum),  32'(tog_sum[j]));
                chk($sformatf("tog_cout_%0d", j), 32'(cout), 32'(tog_cout[j]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
